// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
// Holds the FSM state encoding and the bit-counter width function.
package serial_adder_pkg;

    // Controller states: waiting for operands, shifting bits, holding the result
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit counter width: enough to index WIDTH bits, never narrower than one bit
    function automatic int cnt_w(input int width);
        int w;
        w = $clog2(width);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder cell used as the datapath of the bit-serial adder.
module serial_adder_full_adder (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = x ^ y ^ cin;
    assign cout = (x & y) | (cin & (x ^ y));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder with valid/ready handshakes on input and output.
// Operands are shifted LSB first through one full adder cell with a registered carry.
// Optional signed-overflow output is enabled by defining SERIAL_ADD_OVF_EN.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int               CNT_W    = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [WIDTH-1:0] sum_sh_next;
    logic             carry_q;
    logic [CNT_W-1:0] bit_cnt;
    logic             fa_s;
    logic             fa_cout;
    logic             accept;
    logic             last_bit;

    assign accept   = (state_reg == IDLE) && in_valid;
    assign last_bit = (state_reg == RUN) && (bit_cnt == LAST_BIT);

    serial_adder_full_adder u_fa (
        .x    (a_sh[0]),
        .y    (b_sh[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_cout)
    );

    // New sum bit enters at the MSB so that after WIDTH shifts bit 0 lands at the LSB
    generate
        if (WIDTH == 1) begin : g_single
            assign sum_sh_next = fa_s;
        end else begin : g_multi
            assign sum_sh_next = {fa_s, sum_sh[WIDTH-1:1]};
        end
    endgenerate

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: accept only in IDLE, leave RUN after the last bit, release on out_ready
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (in_valid)           state_next = RUN;
            RUN:     if (bit_cnt == LAST_BIT) state_next = DONE;
            DONE:    if (out_ready)          state_next = IDLE;
            default:                         state_next = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state
    always_comb begin
        in_ready  = (state_reg == IDLE);
        out_valid = (state_reg == DONE);
    end

    // Operand shifters, running carry and bit counter; counter holds on the last bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh    <= '0;
            b_sh    <= '0;
            sum_sh  <= '0;
            carry_q <= 1'b0;
            bit_cnt <= '0;
        end else if (accept) begin
            a_sh    <= a;
            b_sh    <= b;
            carry_q <= cin;
            bit_cnt <= '0;
        end else if (state_reg == RUN) begin
            a_sh    <= a_sh >> 1;
            b_sh    <= b_sh >> 1;
            sum_sh  <= sum_sh_next;
            carry_q <= fa_cout;
            if (!last_bit) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
        end
    end

    // Result registers update only when the final bit is produced and hold otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum  <= '0;
            cout <= 1'b0;
        end else if (last_bit) begin
            sum  <= sum_sh_next;
            cout <= fa_cout;
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    // Signed overflow: carry into the MSB differs from carry out of the MSB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (last_bit) begin
            ovf <= carry_q ^ fa_cout;
        end
    end
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH = 8, 1 and 13.
// Expected results come from an arithmetic reference model through a scoreboard queue.
module tb_serial_adder;

    typedef struct {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_fail = 0;
    int   cyc_cnt = 0;
    exp_t sb[$];

    // WIDTH = 8 instance
    logic       in_valid8 = 1'b0, out_ready8 = 1'b0, cin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       in_ready8, out_valid8, cout8;
    logic [7:0] sum8;
    // WIDTH = 1 instance
    logic       in_valid1 = 1'b0, out_ready1 = 1'b0, cin1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0;
    logic       in_ready1, out_valid1, cout1;
    logic [0:0] sum1;
    // WIDTH = 13 instance
    logic        in_valid13 = 1'b0, out_ready13 = 1'b0, cin13 = 1'b0;
    logic [12:0] a13 = '0, b13 = '0;
    logic        in_ready13, out_valid13, cout13;
    logic [12:0] sum13;
`ifdef SERIAL_ADD_OVF_EN
    logic ovf8, ovf1, ovf13;
`endif

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8), .out_valid(out_valid8), .out_ready(out_ready8),
        .sum(sum8), .cout(cout8)
`ifdef SERIAL_ADD_OVF_EN
        , .ovf(ovf8)
`endif
    );

    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .cout(cout1)
`ifdef SERIAL_ADD_OVF_EN
        , .ovf(ovf1)
`endif
    );

    serial_adder #(.WIDTH(13)) u_dut13 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid13), .in_ready(in_ready13),
        .a(a13), .b(b13), .cin(cin13), .out_valid(out_valid13), .out_ready(out_ready13),
        .sum(sum13), .cout(cout13)
`ifdef SERIAL_ADD_OVF_EN
        , .ovf(ovf13)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Advance one clock and settle just past the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: a + b + cin as plain integer arithmetic; ovf from operand/result signs
    function automatic exp_t model(input int w, input logic [63:0] av, input logic [63:0] bv,
                                   input logic cv);
        exp_t        e;
        logic [63:0] mask;
        logic [64:0] full;
        mask   = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        full   = {1'b0, av & mask} + {1'b0, bv & mask} + {64'd0, cv};
        e.sum  = full[63:0] & mask;
        e.cout = full[w];
        e.ovf  = (av[w-1] == bv[w-1]) && (e.sum[w-1] != av[w-1]);
        return e;
    endfunction

    // One complete transaction on the WIDTH=8 instance
    task automatic do_op8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                          input string name);
        exp_t e;
        int   n;
        sb.push_back(model(8, 64'(av), 64'(bv), cv));
        a8 = av; b8 = bv; cin8 = cv; in_valid8 = 1'b1;
        n = 0;
        while (!in_ready8 && n < 100) begin tick(); n++; end
        tick();
        in_valid8 = 1'b0;
        n = 0;
        while (!out_valid8 && n < 100) begin tick(); n++; end
        e = sb.pop_front();
        n_vec++;
        if (n !== 8) begin
            n_fail++;
            $display("FAIL %s latency: got %0d cycles, expected 8", name, n);
        end
        n_vec++;
        if (sum8 !== e.sum[7:0] || cout8 !== e.cout) begin
            n_fail++;
            $display("FAIL %s result: sum=%h cout=%b, expected sum=%h cout=%b",
                     name, sum8, cout8, e.sum[7:0], e.cout);
        end
`ifdef SERIAL_ADD_OVF_EN
        n_vec++;
        if (ovf8 !== e.ovf) begin
            n_fail++;
            $display("FAIL %s ovf: got %b, expected %b", name, ovf8, e.ovf);
        end
`endif
        $display("op %s: %h + %h + %b -> sum=%h cout=%b after %0d cycles", name, av, bv, cv,
                 sum8, cout8, n);
        out_ready8 = 1'b1;
        tick();
        out_ready8 = 1'b0;
        n_vec++;
        if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1) begin
            n_fail++;
            $display("FAIL %s handoff: out_valid=%b in_ready=%b, expected 0/1",
                     name, out_valid8, in_ready8);
        end
    endtask

    task automatic test_reset();
        n_vec++;
        if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0 || sum8 !== 8'h00 || cout8 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset8: in_ready=%b out_valid=%b sum=%h cout=%b, expected 1/0/00/0",
                     in_ready8, out_valid8, sum8, cout8);
        end
        n_vec++;
        if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0 || in_ready13 !== 1'b1 ||
            out_valid13 !== 1'b0 || sum13 !== 13'd0) begin
            n_fail++;
            $display("FAIL reset1_13: rdy1=%b vld1=%b rdy13=%b vld13=%b sum13=%h",
                     in_ready1, out_valid1, in_ready13, out_valid13, sum13);
        end
`ifdef SERIAL_ADD_OVF_EN
        n_vec++;
        if (ovf8 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ovf: got %b, expected 0", ovf8);
        end
`endif
        $display("reset: in_ready=%b out_valid=%b sum=%h cout=%b", in_ready8, out_valid8,
                 sum8, cout8);
    endtask

    task automatic test_basic();
        do_op8(8'h3C, 8'h0A, 1'b0, "3C+0A");
        do_op8(8'hFF, 8'h01, 1'b0, "FF+01");
        do_op8(8'h7F, 8'h01, 1'b0, "7F+01");
        do_op8(8'h80, 8'h80, 1'b0, "80+80");
        do_op8(8'h00, 8'h00, 1'b1, "00+00+1");
    endtask

    // Result held under back-pressure; in_valid during RUN is ignored
    task automatic test_hold();
        exp_t e;
        int   n;
        logic stable;
        logic quiet;
        sb.push_back(model(8, 64'hFF, 64'hFF, 1'b1));
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; in_valid8 = 1'b1;
        tick();
        a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0;
        n_vec++;
        if (in_ready8 !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_run_ready: in_ready=%b during RUN, expected 0", in_ready8);
        end
        tick();
        tick();
        in_valid8 = 1'b0;
        n = 2;
        while (!out_valid8 && n < 100) begin tick(); n++; end
        e = sb.pop_front();
        n_vec++;
        if (n !== 8 || sum8 !== e.sum[7:0] || cout8 !== e.cout) begin
            n_fail++;
            $display("FAIL hold_result: sum=%h cout=%b lat=%0d, expected sum=%h cout=%b lat=8",
                     sum8, cout8, n, e.sum[7:0], e.cout);
        end
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (out_valid8 !== 1'b1 || sum8 !== e.sum[7:0] || cout8 !== e.cout) stable = 1'b0;
        end
        n_vec++;
        if (stable !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_stable: out_valid=%b sum=%h cout=%b, expected 1/%h/%b",
                     out_valid8, sum8, cout8, e.sum[7:0], e.cout);
        end
        $display("op hold FF+FF+1: sum=%h cout=%b held 5 cycles", sum8, cout8);
        out_ready8 = 1'b1;
        tick();
        out_ready8 = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid8 !== 1'b0 || sum8 !== e.sum[7:0]) quiet = 1'b0;
        end
        n_vec++;
        if (quiet !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_ignored: out_valid=%b sum=%h, expected 0 and held %h",
                     out_valid8, sum8, e.sum[7:0]);
        end
    endtask

    // Asynchronous reset at bit 3 aborts the operation
    task automatic test_reset_mid();
        a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0; in_valid8 = 1'b1;
        tick();
        in_valid8 = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (out_valid8 !== 1'b0 || sum8 !== 8'h00 || cout8 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: out_valid=%b sum=%h cout=%b, expected 0/00/0",
                     out_valid8, sum8, cout8);
        end
        tick(); tick();
        rst_n = 1'b1;
        tick();
        n_vec++;
        if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b, expected 1/0",
                     in_ready8, out_valid8);
        end
        $display("op abort AA+55 at bit 3: sum=%h out_valid=%b", sum8, out_valid8);
        do_op8(8'h01, 8'h01, 1'b0, "01+01");
    endtask

    // Streaming with in_valid and out_ready tied high
    task automatic test_back_to_back();
        exp_t       e;
        int         n;
        int         t_prev;
        int         t_acc;
        logic [7:0] av, bv;
        logic       cv;
        t_prev = 0;
        out_ready8 = 1'b1;
        in_valid8 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            av = 8'($urandom); bv = 8'($urandom); cv = 1'($urandom);
            a8 = av; b8 = bv; cin8 = cv;
            sb.push_back(model(8, 64'(av), 64'(bv), cv));
            n = 0;
            while (!in_ready8 && n < 100) begin tick(); n++; end
            t_acc = cyc_cnt;
            if (i > 0) begin
                n_vec++;
                if (t_acc - t_prev !== 10) begin
                    n_fail++;
                    $display("FAIL b2b_spacing[%0d]: got %0d cycles, expected 10", i,
                             t_acc - t_prev);
                end
            end
            t_prev = t_acc;
            tick();
            n = 0;
            while (!out_valid8 && n < 100) begin tick(); n++; end
            e = sb.pop_front();
            n_vec++;
            if (sum8 !== e.sum[7:0] || cout8 !== e.cout) begin
                n_fail++;
                $display("FAIL b2b_result[%0d]: sum=%h cout=%b, expected sum=%h cout=%b",
                         i, sum8, cout8, e.sum[7:0], e.cout);
            end
            $display("op b2b[%0d]: %h + %h + %b -> sum=%h cout=%b", i, av, bv, cv, sum8, cout8);
        end
        in_valid8 = 1'b0;
        tick();
        out_ready8 = 1'b0;
    endtask

    // WIDTH=1: all eight input combinations, one-cycle RUN
    task automatic test_width1();
        exp_t e;
        int   n;
        for (int v = 0; v < 8; v++) begin
            a1 = 1'(v >> 2); b1 = 1'(v >> 1); cin1 = 1'(v);
            sb.push_back(model(1, 64'(a1), 64'(b1), cin1));
            in_valid1 = 1'b1;
            n = 0;
            while (!in_ready1 && n < 100) begin tick(); n++; end
            tick();
            in_valid1 = 1'b0;
            n = 0;
            while (!out_valid1 && n < 100) begin tick(); n++; end
            e = sb.pop_front();
            n_vec++;
            if (n !== 1 || sum1 !== e.sum[0:0] || cout1 !== e.cout) begin
                n_fail++;
                $display("FAIL w1[%0d]: sum=%b cout=%b lat=%0d, expected sum=%b cout=%b lat=1",
                         v, sum1, cout1, n, e.sum[0], e.cout);
            end
            $display("op w1: %b + %b + %b -> sum=%b cout=%b", a1, b1, cin1, sum1, cout1);
            out_ready1 = 1'b1;
            tick();
            out_ready1 = 1'b0;
        end
    endtask

    // WIDTH=13: random operands with random output back-pressure
    task automatic test_random13();
        exp_t e;
        int   n;
        int   bad;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            a13 = 13'($urandom); b13 = 13'($urandom); cin13 = 1'($urandom);
            sb.push_back(model(13, 64'(a13), 64'(b13), cin13));
            in_valid13 = 1'b1;
            n = 0;
            while (!in_ready13 && n < 100) begin tick(); n++; end
            tick();
            in_valid13 = 1'b0;
            n = 0;
            while (!out_valid13 && n < 100) begin tick(); n++; end
            e = sb.pop_front();
            n_vec++;
            if (n !== 13 || sum13 !== e.sum[12:0] || cout13 !== e.cout
`ifdef SERIAL_ADD_OVF_EN
                || ovf13 !== e.ovf
`endif
               ) begin
                n_fail++;
                bad++;
                $display("FAIL rand13[%0d]: sum=%h cout=%b lat=%0d, expected sum=%h cout=%b lat=13",
                         i, sum13, cout13, n, e.sum[12:0], e.cout);
            end
            $display("op r13[%0d]: %h + %h + %b -> sum=%h cout=%b", i, a13, b13, cin13,
                     sum13, cout13);
            repeat ($urandom_range(0, 3)) tick();
            out_ready13 = 1'b1;
            tick();
            out_ready13 = 1'b0;
        end
        $display("random13: 1000 ops, %0d bad", bad);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        test_reset();
        test_basic();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        test_width1();
        test_random13();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
